// File: rtl/alu_exec_stage.sv
// Execute stage downstream of controlUnit: captures an ALU operation through valid/ready.
// Single-cycle ops finish at once; shifts and rotates step one bit per clock; the result holds until taken.
module alu_exec_stage #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluOp,
    input  logic             cIn,
    input  logic             Sh_LR,
    input  logic             rotEn,
    input  logic             cmpEn,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_PASS = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_ASL  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;
    localparam logic [3:0] OP_CMP  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state;
    state_e           state_nxt;

    logic             accept;
    logic             start_shift;
    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] work;
    logic             asl_v;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_z;
    logic             alu_n;
    logic             alu_v;

    logic [WIDTH-1:0] step_w;
    logic             step_c;
    logic             step_v;

    // The qualifiers only restate what aluOp already encodes; aluOp is authoritative.
    logic             unused_quals;
    assign unused_quals = ^{cIn, Sh_LR, rotEn, cmpEn};

    function automatic logic is_shift_op(input logic [3:0] op);
        return op[3] && (op[2:1] != 2'b11);
    endfunction

    assign in_ready    = (state == IDLE) && !rst;
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign shamt       = op_b[SHW-1:0];
    assign start_shift = is_shift_op(aluOp) && (shamt != '0);

    // Single-cycle datapath, evaluated on the live inputs so the result lands on the accept edge.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        sum     = {1'b0, op_a} + {1'b0, op_b};
        diff    = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluOp)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_PASS: alu_res = op_b;
            OP_CMP: begin
                alu_res = op_a;
                alu_c   = diff[WIDTH];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            // A zero-amount shift or rotate passes A through with no bit shifted out.
            OP_SLL, OP_SRL, OP_ASL, OP_ASR, OP_ROL, OP_ROR: alu_res = op_a;
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == '0);
        alu_n = alu_res[MSB];
        if (aluOp == OP_CMP) begin
            alu_z = (op_a == op_b);
            alu_n = diff[MSB];
        end
    end

    // One bit of shift/rotate on the working register.
    always_comb begin
        step_w = work;
        step_c = 1'b0;
        step_v = 1'b0;
        case (op_r)
            OP_SLL: begin
                step_w = {work[MSB-1:0], 1'b0};
                step_c = work[MSB];
            end
            OP_ASL: begin
                step_w = {work[MSB-1:0], 1'b0};
                step_c = work[MSB];
                step_v = work[MSB] ^ work[MSB-1];
            end
            OP_SRL: begin
                step_w = {1'b0, work[MSB:1]};
                step_c = work[0];
            end
            OP_ASR: begin
                step_w = {work[MSB], work[MSB:1]};
                step_c = work[0];
            end
            OP_ROL: begin
                step_w = {work[MSB-1:0], work[MSB]};
                step_c = work[MSB];
            end
            OP_ROR: begin
                step_w = {work[0], work[MSB:1]};
                step_c = work[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = start_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every process sees the value from before the edge.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: op_r, work, cnt and asl_v are only meaningful inside SHIFT, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= aluOp;
                        work  <= op_a;
                        cnt   <= shamt;
                        asl_v <= 1'b0;
                        if (!start_shift) begin
                            result <= alu_res;
                            flag_c <= alu_c;
                            flag_z <= alu_z;
                            flag_n <= alu_n;
                            flag_v <= alu_v;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step_w;
                    cnt   <= cnt - SHW'(1);
                    asl_v <= asl_v | step_v;
                    if (cnt == SHW'(1)) begin
                        result <= step_w;
                        flag_c <= step_c;
                        flag_z <= (step_w == '0);
                        flag_n <= step_w[MSB];
                        flag_v <= asl_v | step_v;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors, latency, backpressure and mid-op reset.
module tb_alu_exec_stage;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluOp;
    logic             cIn;
    logic             Sh_LR;
    logic             rotEn;
    logic             cmpEn;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluOp     (aluOp),
        .cIn       (cIn),
        .Sh_LR     (Sh_LR),
        .rotEn     (rotEn),
        .cmpEn     (cmpEn),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op for a single accept edge; bad=1 inverts every qualifier to show aluOp wins.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic bad);
        aluOp = op;
        op_a  = a;
        op_b  = b;
        cIn   = (op == 4'h0) || (op == 4'h1);
        Sh_LR = op[0];
        rotEn = (op == 4'hC) || (op == 4'hD);
        cmpEn = (op == 4'hE);
        if (bad) begin
            cIn   = ~cIn;
            Sh_LR = ~Sh_LR;
            rotEn = ~rotEn;
            cmpEn = ~cmpEn;
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // lat = clock edges after the accept edge until out_valid is seen.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic bad, input int lat,
                          input logic [7:0] res, input logic c, input logic z,
                          input logic n, input logic v);
        int edges;
        edges = 0;
        issue(op, a, b, bad);
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check({tag, " latency"}, edges, lat);
        check({tag, " result"}, result, res);
        check({tag, " C"}, flag_c, c);
        check({tag, " Z"}, flag_z, z);
        check({tag, " N"}, flag_n, n);
        check({tag, " V"}, flag_v, v);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " released"}, out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluOp     = 4'h0;
        cIn       = 1'b0;
        Sh_LR     = 1'b0;
        rotEn     = 1'b0;
        cmpEn     = 1'b0;
        op_a      = 8'h00;
        op_b      = 8'h00;

        tick();
        tick();
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        check("reset result", result, 8'h00);
        check("reset flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0000);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);

        //      tag          op     a      b      bad  lat res    C     Z     N     V
        run_op("add_ff_01",  4'h0, 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub_80_01",  4'h1, 8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("asr_90_3",   4'hB, 8'h90, 8'h03, 1'b0, 3, 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("rol_81_1",   4'hC, 8'h81, 8'h01, 1'b0, 1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("cmp_05_05",  4'hE, 8'h05, 8'h05, 1'b0, 0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("cmp_03_05",  4'hE, 8'h03, 8'h05, 1'b0, 0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("add_7f_01",  4'h0, 8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("xor_f0_ff",  4'h4, 8'hF0, 8'hFF, 1'b0, 0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("not_5a",     4'h5, 8'h5A, 8'h00, 1'b0, 0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("asl_40_2",   4'hA, 8'h40, 8'h02, 1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        run_op("ror_01_7q",  4'hD, 8'h01, 8'h07, 1'b1, 7, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("srl_a5_0",   4'h9, 8'hA5, 8'h08, 1'b0, 0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("rsvd_7",     4'h7, 8'h12, 8'h34, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure: result must hold and a waiting request must not slip in.
        issue(4'h0, 8'h01, 8'h02, 1'b0);
        check("stall first valid", out_valid, 1'b1);
        aluOp    = 4'h1;
        op_a     = 8'h10;
        op_b     = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall result", result, 8'h03);
            check("stall out_valid", out_valid, 1'b1);
            check("stall in_ready", in_ready, 1'b0);
        end
        check("stall flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff out_valid", out_valid, 1'b0);
        check("handoff in_ready", in_ready, 1'b1);
        check("handoff result held", result, 8'h03);
        tick();
        in_valid = 1'b0;
        check("queued op valid", out_valid, 1'b1);
        check("queued op result", result, 8'h0F);
        check("queued op C", flag_c, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset two cycles into a long shift aborts it with no output.
        issue(4'h8, 8'h01, 8'h07, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort out_valid", out_valid, 1'b0);
        check("abort in_ready", in_ready, 1'b0);
        check("abort result", result, 8'h00);
        check("abort flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0000);
        rst = 1'b0;
        #1;
        check("abort release in_ready", in_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("abort no stale output", stale, 0);
        run_op("sll_01_7",   4'h8, 8'h01, 8'h07, 1'b0, 7, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
